// File: rtl/gray_rx_mon.sv
// Gray-code receive monitor: captures an upstream Gray count, decodes it to binary and
// classifies each transition. Define GRAY_RX_SYNC_EN for a two-flop input synchronizer.
module gray_rx_mon #(
  parameter int W     = 3,
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [W-1:0]     gray_in,
  input  logic             clr,
  output logic [W-1:0]     bin_out,
  output logic             step,
  output logic             wrap,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fault,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [W-1:0]     BIN_ONE = W'(1);
  localparam logic [LAP_W-1:0] LAP_ONE = LAP_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [W-1:0] g_new_q;

`ifdef GRAY_RX_SYNC_EN
  logic [W-1:0] s1_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_q    <= '0;
      g_new_q <= '0;
    end else begin
      s1_q    <= gray_in;
      g_new_q <= s1_q;
    end
  end
`else
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      g_new_q <= '0;
    end else begin
      g_new_q <= gray_in;
    end
  end
`endif

  state_t           state_q, state_d;
  logic [W-1:0]     g_prev_q, g_prev_d;
  logic [W-1:0]     bin_q, bin_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fault_q, fault_d;

  logic [W-1:0]     new_bin;
  logic [W-1:0]     prev_bin;
  logic [W-1:0]     inc_bin;
  logic             is_hold;
  logic             is_step;
  logic [ERR_W-1:0] err_sat;

  assign new_bin  = gray2bin(g_new_q);
  assign prev_bin = gray2bin(g_prev_q);
  assign inc_bin  = prev_bin + BIN_ONE;
  assign is_hold  = (new_bin == prev_bin);
  assign is_step  = (new_bin == inc_bin);
  assign err_sat  = (err_q == '1) ? err_q : err_q + ERR_ONE;

  always_comb begin
    state_d  = state_q;
    g_prev_d = g_prev_q;
    bin_d    = bin_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    lap_d    = lap_q;
    err_d    = err_q;
    fault_d  = fault_q;
    // clr wins over classification; bin/g_prev are reloaded by the following IDLE cycle
    if (clr) begin
      state_d = IDLE;
      lap_d   = '0;
      err_d   = '0;
      fault_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          g_prev_d = g_new_q;
          bin_d    = new_bin;
          state_d  = TRACK;
        end
        TRACK: begin
          if (!is_hold) begin
            g_prev_d = g_new_q;
            bin_d    = new_bin;
            if (is_step) begin
              step_d = 1'b1;
              if (new_bin == '0) begin
                wrap_d = 1'b1;
                lap_d  = lap_q + LAP_ONE;
              end
            end else begin
              err_d   = err_sat;
              fault_d = 1'b1;
              state_d = FAULT;
            end
          end
        end
        FAULT: begin
          // keep following the code so bin_out stays usable; only illegal moves count
          if (!is_hold) begin
            g_prev_d = g_new_q;
            bin_d    = new_bin;
            if (!is_step) begin
              err_d = err_sat;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      g_prev_q <= '0;
      bin_q    <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      lap_q    <= '0;
      err_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_prev_q <= g_prev_d;
      bin_q    <= bin_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      lap_q    <= lap_d;
      err_q    <= err_d;
      fault_q  <= fault_d;
    end
  end

  assign bin_out     = bin_q;
  assign step        = step_q;
  assign wrap        = wrap_q;
  assign lap_cnt     = lap_q;
  assign err_cnt     = err_q;
  assign fault       = fault_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gray_rx_mon.sv
// Self-checking bench for gray_rx_mon: a behavioural model feeds an expected-value queue
// that is compared against the DUT outputs every cycle, plus directed value checks.
module tb_gray_rx_mon;

  localparam int W     = 3;
  localparam int LAP_W = 8;
  localparam int ERR_W = 4;
`ifdef GRAY_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             n_rst;
  logic [W-1:0]     gray_in;
  logic             clr;
  logic [W-1:0]     bin_out;
  logic             step;
  logic             wrap;
  logic [LAP_W-1:0] lap_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             fault;
  logic [1:0]       dbg_state;
  logic [17:0]      dut_vec;

  gray_rx_mon #(.W(W), .LAP_W(LAP_W), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .gray_in     (gray_in),
    .clr         (clr),
    .bin_out     (bin_out),
    .step        (step),
    .wrap        (wrap),
    .lap_cnt     (lap_cnt),
    .err_cnt     (err_cnt),
    .fault       (fault),
    .dbg_state_o (dbg_state)
  );

  assign dut_vec = {bin_out, step, wrap, lap_cnt, err_cnt, fault};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_mis = 0;
  logic [17:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural reference model
  int m_st, m_prev, m_bin, m_lap, m_err;
  int cap0, cap1;
  bit m_step, m_wrap, m_fault;
  int last_code;

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b & ((1 << W) - 1);
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & ((1 << W) - 1);
  endfunction

  task automatic model_reset();
    m_st = 0; m_prev = 0; m_bin = 0; m_lap = 0; m_err = 0;
    cap0 = 0; cap1 = 0; m_step = 0; m_wrap = 0; m_fault = 0;
  endtask

  task automatic model_step(input int code, input bit clrv);
    int gnew, nb, inc;
    gnew = (LAT == 2) ? cap1 : cap0;
    nb   = g2b(gnew);
    inc  = (m_prev + 1) % (1 << W);
    m_step = 0;
    m_wrap = 0;
    if (clrv) begin
      m_lap = 0; m_err = 0; m_fault = 0; m_st = 0;
    end else if (m_st == 0) begin
      m_bin = nb; m_prev = nb; m_st = 1;
    end else if (nb != m_prev) begin
      if (m_st == 1) begin
        if (nb == inc) begin
          m_step = 1;
          if (nb == 0) begin
            m_wrap = 1;
            m_lap  = (m_lap + 1) % (1 << LAP_W);
          end
        end else begin
          if (m_err < 15) m_err++;
          m_fault = 1;
          m_st    = 2;
        end
      end else if (nb != inc) begin
        if (m_err < 15) m_err++;
      end
      m_bin  = nb;
      m_prev = nb;
    end
    cap1 = cap0;
    cap0 = code;
  endtask

  function automatic logic [17:0] model_vec();
    return {m_bin[2:0], m_step, m_wrap, m_lap[7:0], m_err[3:0], m_fault};
  endfunction

  // driver tasks
  task automatic cycle(input int code, input bit clrv);
    @(negedge clk);
    if (exp_q.size() > 0) check_eq("scoreboard", 32'(dut_vec), 32'(exp_q.pop_front()));
    gray_in   = code[2:0];
    clr       = clrv;
    last_code = code;
    model_step(code, clrv);
    exp_q.push_back(model_vec());
  endtask

  task automatic hold(input int n);
    repeat (n) cycle(last_code, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    if (exp_q.size() > 0) check_eq("scoreboard", 32'(dut_vec), 32'(exp_q.pop_front()));
    n_rst     = 1'b0;
    gray_in   = '0;
    clr       = 1'b0;
    last_code = 0;
    model_reset();
    #1;
    check_eq("midreset_outputs", 32'(dut_vec), 32'd0);
    check_eq("midreset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    model_step(0, 1'b0);
    exp_q.push_back(model_vec());
  endtask

  initial begin
    int n;
    int r;
    int nxt;
    n_rst     = 1'b0;
    gray_in   = '0;
    clr       = 1'b0;
    last_code = 0;
    model_reset();
    #3;
    check_eq("reset_outputs", 32'(dut_vec), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    #19;
    n_rst = 1'b1;
    model_step(0, 1'b0);
    exp_q.push_back(model_vec());

    // free-running upstream count: 16 legal steps, two wraps
    for (int k = 1; k <= 16; k++) cycle(b2g(k % 8), 1'b0);
    hold(3);
    check_eq("lap_after_16", 32'(lap_cnt), 32'd2);
    check_eq("err_after_16", 32'(err_cnt), 32'd0);
    check_eq("fault_after_16", 32'(fault), 32'd0);

    // holds between steps
    cycle(0, 1'b0); cycle(1, 1'b0); cycle(1, 1'b0); cycle(1, 1'b0); cycle(3, 1'b0);
    hold(2);
    check_eq("bin_after_holds", 32'(bin_out), 32'd2);

    // skip 0 -> 2, then +1 while faulted
    cycle(0, 1'b0); hold(3);
    cycle(0, 1'b1); hold(3);
    cycle(3, 1'b0); hold(2);
    check_eq("skip_err", 32'(err_cnt), 32'd1);
    check_eq("skip_bin", 32'(bin_out), 32'd2);
    cycle(2, 1'b0); hold(3);
    check_eq("fault_step_err", 32'(err_cnt), 32'd1);
    check_eq("fault_step_bin", 32'(bin_out), 32'd3);
    check_eq("fault_sticky", 32'(fault), 32'd1);

    // backward move, then saturation
    cycle(3, 1'b0); hold(3);
    cycle(3, 1'b1); hold(3);
    check_eq("clr_err", 32'(err_cnt), 32'd0);
    cycle(1, 1'b0); hold(3);
    check_eq("back_err", 32'(err_cnt), 32'd1);
    check_eq("back_fault", 32'(fault), 32'd1);
    for (int i = 0; i < 20; i++) cycle((i % 2 == 0) ? 0 : 3, 1'b0);
    hold(3);
    check_eq("err_saturated", 32'(err_cnt), 32'd15);

    // clr out of FAULT, then legal stepping resumes
    cycle(3, 1'b1);
    cycle(3, 1'b0);
    check_eq("clr_fault", 32'(fault), 32'd0);
    check_eq("clr_err2", 32'(err_cnt), 32'd0);
    check_eq("clr_lap", 32'(lap_cnt), 32'd0);
    hold(2);
    for (int k = 3; k <= 12; k++) cycle(b2g(k % 8), 1'b0);
    hold(2);
    check_eq("lap_after_clr", 32'(lap_cnt), 32'd1);

    // capture latency of a single step
    cycle(b2g(5), 1'b0);
    n = 0;
    while (n < 10 && bin_out != 3'd5) begin
      cycle(b2g(5), 1'b0);
      n++;
    end
    check_eq("latency", 32'(n), 32'(LAT + 1));

    // mid-count reset at bin 5, upstream restarts from 0
    reset_pulse();
    for (int k = 1; k <= 10; k++) cycle(b2g(k % 8), 1'b0);
    hold(2);
    check_eq("post_reset_err", 32'(err_cnt), 32'd0);
    check_eq("post_reset_lap", 32'(lap_cnt), 32'd1);

    // random mix of steps, holds, jumps and clears
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12) nxt = b2g((g2b(last_code) + 1) % 8);
      else if (r < 16) nxt = last_code;
      else nxt = $urandom_range(0, 7);
      cycle(nxt, (r == 19));
    end
    hold(3);
    @(negedge clk);
    if (exp_q.size() > 0) check_eq("scoreboard", 32'(dut_vec), 32'(exp_q.pop_front()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
